// File: rtl/axi_uart_rx_poller.sv
// axi_uart_rx_poller: polls a UART STAT/RX register pair over AXI4-Lite and buffers received bytes
module axi_uart_rx_poller #(
  parameter int POLL_GAP  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        clr_i,
  output logic [3:0]  m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic [7:0]  byte_o,
  output logic        byte_valid_o,
  input  logic        byte_ready_i,
  output logic        overrun_o,
  output logic        frame_err_o,
  output logic        parity_err_o,
  output logic        resp_err_o,
  output logic        eol_o
);
  localparam int AW = $clog2(OUT_DEPTH);
  typedef enum logic [2:0] {GAP, AR_STAT, R_STAT, AR_DATA, R_DATA} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d, eol_q, eol_d;
  logic [3:0] araddr_q, araddr_d;
  logic [3:0] err_q, err_d;
  logic [7:0] mem_q [OUT_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] occ_q, occ_d;
  logic r_hs, rsp_ok, push, pop;
  logic unused_rdata;
  assign unused_rdata = ^m_axi_rdata[31:8];
  assign m_axi_araddr = araddr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready = rready_q;
  assign byte_valid_o = occ_q != '0;
  assign byte_o = byte_valid_o ? mem_q[rptr_q] : 8'h00;
  assign eol_o = eol_q;
  assign {resp_err_o, parity_err_o, frame_err_o, overrun_o} = err_q;
  always_comb begin
    r_hs = rready_q && m_axi_rvalid;
    rsp_ok = m_axi_rresp == 2'b00;
    push = state_q == R_DATA && r_hs && rsp_ok;
    pop = byte_valid_o && byte_ready_i;
    occ_d = occ_q + (AW+1)'(push) - (AW+1)'(pop);
    wptr_d = wptr_q + AW'(push);
    rptr_d = rptr_q + AW'(pop);
    eol_d = pop && byte_o == 8'h0A;
    // a flag being set in the same cycle as clr_i survives the clear
    err_d = (clr_i ? 4'b0000 : err_q) |
            {r_hs && !rsp_ok, state_q == R_STAT && r_hs && rsp_ok ? m_axi_rdata[7:5] : 3'b000};
    state_d = state_q;
    cnt_d = '0;
    arvalid_d = arvalid_q;
    araddr_d = araddr_q;
    rready_d = rready_q;
    case (state_q)
      GAP: begin
        cnt_d = cnt_q == 8'(POLL_GAP) ? (enable_i ? 8'd0 : cnt_q) : cnt_q + 8'd1;
        if (cnt_q == 8'(POLL_GAP) && enable_i) begin
          state_d = AR_STAT;
          arvalid_d = 1'b1;
          araddr_d = 4'h8;
        end
      end
      AR_STAT, AR_DATA: if (m_axi_arready) begin
        state_d = state_q == AR_STAT ? R_STAT : R_DATA;
        arvalid_d = 1'b0;
        rready_d = 1'b1;
      end
      R_STAT: if (m_axi_rvalid) begin
        rready_d = 1'b0;
        state_d = GAP;
        if (rsp_ok && m_axi_rdata[0] && occ_q != (AW+1)'(OUT_DEPTH)) begin
          state_d = AR_DATA;
          arvalid_d = 1'b1;
          araddr_d = 4'h0;
        end
      end
      R_DATA: if (m_axi_rvalid) begin
        rready_d = 1'b0;
        state_d = GAP;
      end
      default: state_d = GAP;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= GAP;
      cnt_q <= '0;
      arvalid_q <= 1'b0;
      araddr_q <= '0;
      rready_q <= 1'b0;
      eol_q <= 1'b0;
      err_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      arvalid_q <= arvalid_d;
      araddr_q <= araddr_d;
      rready_q <= rready_d;
      eol_q <= eol_d;
      err_q <= err_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q <= occ_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= m_axi_rdata[7:0];
  end
endmodule

// File: tb/tb_axi_uart_rx_poller.sv
// tb_axi_uart_rx_poller: randomized AXI slave + scoreboard bench for axi_uart_rx_poller
module tb_axi_uart_rx_poller;
  localparam int PG = 4, DEPTH = 4;
  logic clk = 0, rst = 1, en = 0, clr = 0, ready = 0;
  logic [3:0] araddr;
  logic arvalid, arready, rvalid, rready, bvalid, eol_o;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic [7:0] byte_o;
  logic ovr, frm, par, rerr;
  int checks = 0, errors = 0;
  logic [7:0] exp_q[$], src[$];
  logic [3:0] exp_fl = 0, exp_addr = 4'h8, raddr = 0;
  logic eol_exp = 0, pend = 0;
  int eol_cnt = 0, delivered = 0, awt = 0, rmax = 0, err_rate = 0, rcnt = 0, acnt = 0;
  logic [2:0] force_st = 0;
  logic force_st_v = 0, force_dresp_v = 0;
  logic [1:0] force_dresp = 0;
  logic ar_hs, r_hs, pop_s, clr_s, rst_s = 1, prev_wait = 0;
  logic [3:0] addr_s, prev_addr;
  logic [31:0] r32;
  logic [2:0] st;
  int occ, d0, e0, k;
  int rises[$];
  logic prev_av;

  axi_uart_rx_poller #(.POLL_GAP(PG), .OUT_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .clr_i(clr),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .byte_o(byte_o), .byte_valid_o(bvalid), .byte_ready_i(ready),
    .overrun_o(ovr), .frame_err_o(frm), .parity_err_o(par), .resp_err_o(rerr), .eol_o(eol_o)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reactive AXI slave, reference model and output monitor in one deterministic loop
  initial begin
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    forever begin
      @(negedge clk);
      if (!rst_s) begin
        chk("flags", {rerr, par, frm, ovr}, exp_fl);
        chk("byte_valid", bvalid, exp_q.size() != 0);
        chk("eol", eol_o, eol_exp);
        if (prev_wait) chk("ar_stable", {arvalid, araddr}, {1'b1, prev_addr});
        eol_cnt += eol_o;
      end
      ar_hs = arvalid && arready;
      r_hs = rready && rvalid;
      addr_s = araddr;
      pop_s = bvalid && ready;
      clr_s = clr;
      rst_s = rst;
      occ = exp_q.size();
      prev_wait = arvalid && !arready && !rst;
      prev_addr = araddr;
      if (!rst_s && ar_hs) chk("ar_addr", addr_s, exp_addr);
      if (!rst_s && pop_s) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pop_unexpected actual=%0h expected=none", byte_o);
        end else chk("pop_byte", byte_o, exp_q[0]);
      end
      @(posedge clk); #1;
      if (rst_s) begin
        exp_q.delete(); exp_fl = 0; exp_addr = 4'h8; eol_exp = 0;
        pend = 0; rvalid = 0; arready = 0; acnt = 0;
      end else begin
        eol_exp = pop_s && exp_q.size() != 0 && exp_q[0] == 8'h0A;
        if (pop_s && exp_q.size() != 0) void'(exp_q.pop_front());
        if (clr_s) exp_fl = 0;
        if (r_hs) begin
          if (rresp != 2'b00) begin
            exp_fl[3] = 1; exp_addr = 4'h8;
          end else if (raddr == 4'h8) begin
            exp_fl[2:0] |= rdata[7:5];
            exp_addr = (rdata[0] && occ < DEPTH) ? 4'h0 : 4'h8;
          end else begin
            chk("push_room", occ < DEPTH, 1);
            exp_q.push_back(rdata[7:0]); delivered++; exp_addr = 4'h8;
          end
          rvalid = 0;
        end
        if (ar_hs) begin
          arready = 0; pend = 1; raddr = addr_s;
          rcnt = rmax > 0 ? int'($urandom_range(0, rmax)) : 0;
        end
        if (pend) begin
          if (rcnt == 0) begin
            pend = 0; rvalid = 1; r32 = $urandom();
            if (raddr == 4'h8) begin
              st = force_st_v ? force_st : ((err_rate != 0 && $urandom % 16 == 0) ? 3'($urandom) : 3'b000);
              force_st_v = 0;
              rdata = {r32[31:8], st, r32[4:1], src.size() != 0};
              rresp = (err_rate != 0 && $urandom % 16 == 0) ? 2'b10 : 2'b00;
            end else begin
              rdata = {r32[31:8], src.size() != 0 ? src.pop_front() : r32[7:0]};
              rresp = force_dresp_v ? force_dresp : ((err_rate != 0 && $urandom % 12 == 0) ? 2'b11 : 2'b00);
              force_dresp_v = 0;
            end
          end else rcnt--;
        end
        if (awt == 0) arready = !pend && !rvalid;
        else if (!arready && arvalid && !pend && !rvalid) begin
          if (acnt >= awt) begin arready = 1; acnt = 0; end
          else acnt++;
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic drain(string nm);
    int n = 0;
    while ((src.size() != 0 || exp_q.size() != 0) && n < 2000) begin cyc(1); n++; end
    chk(nm, n < 2000, 1);
    cyc(20);
  endtask

  task automatic chk_zero(string nm);
    chk(nm, {araddr, arvalid, rready, byte_o, bvalid, eol_o, rerr, par, frm, ovr}, 0);
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    cyc(3);
    @(negedge clk); chk_zero("reset_outs");
    @(posedge clk); #2; rst = 0; en = 1; ready = 1;
    // single byte after a STAT with RX-ready set
    d0 = delivered; src.push_back(8'h41);
    drain("t27_drain");
    chk("t27_delivered", delivered - d0, 1);
    // idle polling period with an empty UART
    d0 = delivered; rises.delete(); prev_av = arvalid; k = 0;
    repeat (60) begin
      @(negedge clk); k++;
      if (arvalid && !prev_av) rises.push_back(k);
      prev_av = arvalid;
    end
    chk("t28_rises", rises.size() >= 6, 1);
    for (int i = 1; i < rises.size(); i++) chk("t28_period", rises[i] - rises[i-1], PG + 3);
    chk("t28_nopush", delivered - d0, 0);
    // FIFO full back-pressure
    cyc(1); ready = 0;
    for (int i = 0; i < 5; i++) src.push_back(8'h30 + 8'(i));
    cyc(200);
    chk("t29_full", exp_q.size(), DEPTH);
    chk("t29_left", src.size(), 1);
    chk("t29_valid", bvalid, 1);
    ready = 1; cyc(1); ready = 0;
    cyc(100);
    chk("t29_refill", exp_q.size(), DEPTH);
    chk("t29_src", src.size(), 0);
    ready = 1;
    drain("t29_drain");
    // overrun in STAT, then an error response on the data read
    d0 = delivered; force_st = 3'b001; force_st_v = 1; force_dresp = 2'b10; force_dresp_v = 1;
    src.push_back(8'h55);
    drain("t30_drain");
    chk("t30_ovr", ovr, 1);
    chk("t30_resp", rerr, 1);
    chk("t30_nopush", delivered - d0, 0);
    clr = 1; cyc(1); clr = 0;
    @(negedge clk); chk("t30_clr", {ovr, rerr}, 0);
    // reset while the RX address phase is stalled
    cyc(1); awt = 3; src.push_back(8'h77); k = 0;
    while (!(arvalid && araddr == 4'h0) && k < 500) begin cyc(1); k++; end
    chk("t31_reach", k < 500, 1);
    cyc(1);
    chk("t31_held", {arvalid, araddr}, {1'b1, 4'h0});
    rst = 1; cyc(1); rst = 0; awt = 0;
    @(negedge clk); chk_zero("t31_reset_outs");
    k = 0;
    while (!arvalid && k < 50) begin @(negedge clk); k++; end
    chk("t31_restart", k, PG + 1);
    cyc(1); drain("t31_drain");
    // line-terminated stream
    e0 = eol_cnt; d0 = delivered;
    src.push_back(8'h48); src.push_back(8'h69); src.push_back(8'h0A);
    drain("t32_drain");
    chk("t32_bytes", delivered - d0, 3);
    chk("t32_eol", eol_cnt - e0, 1);
    // randomized traffic
    err_rate = 1; rmax = 2;
    for (int i = 0; i < 600; i++) begin
      en = $urandom % 8 != 0;
      ready = $urandom % 3 != 0;
      clr = $urandom % 20 == 0;
      if (i % 40 == 0) awt = $urandom % 3;
      if ($urandom % 6 == 0 && src.size() < 6) src.push_back(i % 9 == 0 ? 8'h0A : 8'($urandom));
      cyc(1);
    end
    clr = 0; en = 1; ready = 1; err_rate = 0;
    drain("rand_drain");
    chk("rand_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
